// File: rtl/life_cell.sv
// ---------------------------------------------------------------------------
// LifeCell -- a single Game-of-Life cell driven by a shared 8-tick timer.
//
// The timer broadcasts tick 0..7, one tick per cycle. On tick k the cell
// adds neighbors[k] to a running count. On tick 7 it applies the
// birth/survive rule and updates its alive bit. An epoch starts only on a
// tick 0 seen while the cell is synchronising, so a partial epoch is never
// evaluated.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   tick_in[2:0]   current tick from the shared timer
//   neighbors[7:0] live flags of the eight neighbours, bit k used on tick k
//   ena            generation enable; low freezes the generation
//   load           synchronous pattern load, highest priority
//   load_value     alive value written by load
//   alive          registered cell state
//   neighbor_count registered running/final live-neighbour count (0..8)
//   update_strobe  one-cycle pulse in the cycle after a rule evaluation
//   seq_error      sticky flag: tick sequence broke while accumulating
// ---------------------------------------------------------------------------
module life_cell #(
  parameter logic [8:0] BIRTH_MASK   = 9'b0_0000_1000,
  parameter logic [8:0] SURVIVE_MASK = 9'b0_0000_1100,
  parameter logic       INIT_ALIVE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tick_in,
  input  logic [7:0] neighbors,
  input  logic       ena,
  input  logic       load,
  input  logic       load_value,
  output logic       alive,
  output logic [3:0] neighbor_count,
  output logic       update_strobe,
  output logic       seq_error
);

  typedef enum logic {
    SYNC  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_expTick;
  logic [3:0] r_count;
  logic       r_alive;
  logic       r_strobe;
  logic       r_seqErr;

  logic       w_nbBit;
  logic [3:0] w_sum;
  logic       w_tickOk;

  // Neighbour bit selected by the current tick and the count it produces.
  // Four bits are enough for the worst case of eight live neighbours.
  assign w_nbBit  = neighbors[tick_in];
  assign w_sum    = r_count + {3'b000, w_nbBit};
  assign w_tickOk = (tick_in == r_expTick);

  // Cell state machine. Priority is load, then ena, then the tick
  // protocol. The strobe defaults low every cycle so it can only ever be
  // a single-cycle pulse following a tick-7 evaluation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SYNC;
      r_expTick <= 3'd0;
      r_count   <= 4'd0;
      r_alive   <= INIT_ALIVE;
      r_strobe  <= 1'b0;
      r_seqErr  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (load) begin
        r_alive <= load_value;
        r_count <= 4'd0;
        r_state <= SYNC;
      end else if (!ena) begin
        // Freezing drops any epoch in progress; the count is left visible.
        r_state <= SYNC;
      end else begin
        case (r_state)
          SYNC: begin
            if (tick_in == 3'd0) begin
              r_count   <= {3'b000, neighbors[0]};
              r_expTick <= 3'd1;
              r_state   <= ACCUM;
            end
          end
          ACCUM: begin
            if (!w_tickOk) begin
              // A broken sequence aborts the epoch. A tick 0 arriving
              // here does not restart; the next tick 0 in SYNC does.
              r_seqErr <= 1'b1;
              r_count  <= 4'd0;
              r_state  <= SYNC;
            end else if (tick_in == 3'd7) begin
              r_alive  <= r_alive ? SURVIVE_MASK[w_sum] : BIRTH_MASK[w_sum];
              r_count  <= w_sum;
              r_strobe <= 1'b1;
              r_state  <= SYNC;
            end else begin
              r_count   <= w_sum;
              r_expTick <= r_expTick + 3'd1;
            end
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

  assign alive          = r_alive;
  assign neighbor_count = r_count;
  assign update_strobe  = r_strobe;
  assign seq_error      = r_seqErr;

endmodule

// File: doc/life_cell.md
Name: life_cell

Overview:
- One Game-of-Life cell. Sits directly downstream of the 8-tick timer.
- Consumes the 3-bit tick sequence 0..7 and serially accumulates one neighbour per tick.
- At tick 7 it applies the birth/survive rule and updates its alive bit.
- An array of these cells, sharing one timer, forms the board; each cell's alive output feeds its neighbours' neighbour vectors.

Parameters:
- BIRTH_MASK, 9'b0_0000_1000, bit n set = dead cell with n live neighbours becomes alive (default: n=3).
- SURVIVE_MASK, 9'b0_0000_1100, bit n set = live cell with n live neighbours stays alive (default: n=2,3).
- INIT_ALIVE, 1'b0, alive value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; the only clock is clk.
- tick_in  input  3  current tick from the 8-tick timer; expected to advance by +1 mod 8 every cycle.
- neighbors  input  8  live flags of the 8 neighbours; neighbors[k] is sampled on tick k.
- ena  input  1  generation enable; low = freeze generation.
- load  input  1  synchronous pattern load strobe.
- load_value  input  1  alive value written when load=1.
- alive  output  1  registered cell state.
- neighbor_count  output  4  registered running or final live-neighbour count, range 0..8.
- update_strobe  output  1  one-cycle pulse, high the cycle after a rule evaluation.
- seq_error  output  1  sticky flag: tick_in broke the +1 sequence while accumulating.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-to-clk release):
  - alive=INIT_ALIVE, neighbor_count=0, update_strobe=0, seq_error=0, state=SYNC, expected_tick=0.
- States:
  - SYNC: waiting for the start of an epoch.
  - ACCUM: collecting neighbours.
- SYNC:
  - When ena=1 and tick_in=0: count<=neighbors[0], expected_tick<=1, go to ACCUM.
  - Any other tick: stay in SYNC, count holds.
  - A cell never evaluates a partial epoch.
- ACCUM, ena=1, tick_in==expected_tick:
  - Ticks 1..6: count<=count+neighbors[tick_in], expected_tick+=1.
  - Tick 7: final=count+neighbors[7], computed 4 bits wide with no overflow (max 8).
    - alive<= alive ? SURVIVE_MASK[final] : BIRTH_MASK[final].
    - neighbor_count<=final, update_strobe<=1 on the next cycle only, go to SYNC.
  - Back-to-back epochs: tick 0 on the cycle after tick 7 starts a new epoch with no gap, because SYNC accepts tick 0 on the same edge.
- ACCUM with tick_in!=expected_tick:
  - seq_error<=1, count<=0, go to SYNC.
  - alive unchanged.
  - If the offending tick is 0, the cell does not restart on that edge; the next tick 0 restarts it.
- ena=0 in any state: go to SYNC, count holds its value, alive holds. Deasserting and re-asserting mid-epoch discards the epoch.
- load=1 has highest priority over ena and tick_in: alive<=load_value, count<=0, go to SYNC, no update_strobe. seq_error is not cleared by load.
- seq_error clears only on reset.
- neighbor_count reflects the accumulating count every cycle; it holds the final value until the next epoch's tick 0.
- Latency: alive changes on the rising edge at which tick_in=7 is sampled; update_strobe is high in the following cycle.
- Reset asserted mid-epoch clears everything immediately, with no clock required.

Test Plan:
- Reset, INIT_ALIVE=0, ena=1, ticks 0..7 with neighbors=8'b0000_0111 -> after tick-7 edge alive=1, neighbor_count=3, update_strobe high exactly 1 cycle.
- Load 1 via load_value=1, then one epoch with neighbors=8'b0000_0001 -> alive=0, neighbor_count=1. Next epoch with 8'b0000_0011 and alive=0 -> alive stays 0 (count 2, no birth).
- Live cell, neighbors=8'hFF -> neighbor_count=8, alive=0. Confirms no 4-bit overflow and 9-bit mask indexing at n=8.
- Ticks 0,1,2,5,6,7 (skipping 3,4) -> seq_error=1 at the edge sampling 5, no update at tick 7, alive unchanged. The next clean 0..7 epoch updates normally and seq_error stays 1.
- Assert rst low at tick 4 mid-epoch -> outputs immediately at reset values. After release, the cell waits in SYNC until tick_in=0.
- Drop ena at tick 3 and raise it at tick 5 -> no update at tick 7. load=1 together with tick_in=7 -> alive=load_value, no update_strobe.
